// File: rtl/ifu_fetch_stage_pkg.sv
// Shared types and constants for the RVNoob instruction-fetch stage.
`timescale 1ns/1ps
package rvnoob_pkg;

   localparam int unsigned XLEN = 64;
   localparam int unsigned ILEN = 32;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h8000_0000;
   localparam logic [ILEN-1:0] NOP              = 32'h0000_0013;
   localparam logic [ILEN-1:0] EBREAK           = 32'h0010_0073;

   // One buffered fetch result handed to decode
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] inst;
   } fetch_pkt_t;

   // Force a fetch address onto a 4-byte boundary
   function automatic logic [XLEN-1:0] align4(input logic [XLEN-1:0] a);
      return a & ~XLEN'(3);
   endfunction

endpackage

// File: rtl/ifu_fetch_stage_if.sv
// Instruction-memory request/response channel plus the fetch->decode channel.
`timescale 1ns/1ps
interface ifu_fetch_stage_if;
   import rvnoob_pkg::*;

   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_rsp_valid;
   logic [ILEN-1:0] imem_rsp_data;

   logic            out_valid;
   logic            out_ready;
   logic [ILEN-1:0] out_inst;
   logic [XLEN-1:0] out_pc;

   // Fetch stage side
   modport master (
      output imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready
   );

   // Memory / decode side
   modport slave (
      input  imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready
   );

endinterface

// File: rtl/ifu_sync_fifo.sv
// Small synchronous FIFO with flush; DEPTH must be a power of two.
`timescale 1ns/1ps
module ifu_sync_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 2
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           din_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   output logic [WIDTH-1:0]           dout_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       full_o,
   output logic                       empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] store_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign dout_o  = store_q[rd_ptr_q];
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   // Pointer and occupancy update; flush empties the queue
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   // Control state registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage write; contents need no reset since count gates visibility
   always_ff @(posedge clk_i) begin
      if (do_push && !flush_i) store_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/ifu_fetch_stage.sv
// RVNoob instruction-fetch stage: PC ownership, credit-limited fetch issue,
// stale-response dropping on redirect, halt, and buffered delivery to decode.
// Define IFU_PERF_EN to add the perf_fetch_cnt / perf_stall_cnt counters.
`timescale 1ns/1ps
module ifu_fetch_stage
   import rvnoob_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned     DEPTH    = 2
) (
   input  logic              clock,
   input  logic              reset,
   ifu_fetch_stage_if.master bus,
   input  logic              redirect_valid,
   input  logic [XLEN-1:0]   redirect_pc,
   input  logic              halt
`ifdef IFU_PERF_EN
   ,
   output logic [63:0]       perf_fetch_cnt,
   output logic [63:0]       perf_stall_cnt
`endif
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam int unsigned SW = CW + 1;
   localparam int unsigned DW = CW + 8;
   localparam int unsigned PW = $bits(fetch_pkt_t);

   logic [XLEN-1:0] pc_q, pc_d;
   logic [DW-1:0]   drop_q, drop_d;

   logic [CW-1:0]   live_cnt, buf_cnt;
   logic [XLEN-1:0] live_head;
   logic            live_empty, live_full, buf_empty, buf_full;
   logic            live_push, live_pop, buf_push, buf_pop;
   logic            req_hs, rsp_stale, rsp_live;
   fetch_pkt_t      buf_din, buf_dout;

   assign req_hs    = bus.imem_req_valid && bus.imem_req_ready;
   assign rsp_stale = bus.imem_rsp_valid && (drop_q != '0);
   assign rsp_live  = bus.imem_rsp_valid && (drop_q == '0) && !live_empty;

   // Only live fetches and buffered words consume credit
   assign bus.imem_req_valid = !halt && !reset &&
                               ((SW'(live_cnt) + SW'(buf_cnt)) < SW'(DEPTH));
   assign bus.imem_req_addr  = pc_q;

   assign live_push = req_hs && !redirect_valid;
   assign live_pop  = rsp_live;
   assign buf_push  = rsp_live && !redirect_valid;
   assign buf_pop   = bus.out_valid && bus.out_ready;
   assign buf_din   = '{pc: live_head, inst: bus.imem_rsp_data};

   assign bus.out_valid = !buf_empty && !reset;
   assign bus.out_pc    = buf_dout.pc;
   assign bus.out_inst  = buf_dout.inst;

   ifu_sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_live_q (
      .clk_i   (clock),
      .rst_i   (reset),
      .push_i  (live_push),
      .din_i   (pc_q),
      .pop_i   (live_pop),
      .flush_i (redirect_valid),
      .dout_o  (live_head),
      .count_o (live_cnt),
      .full_o  (live_full),
      .empty_o (live_empty)
   );

   ifu_sync_fifo #(.WIDTH(PW), .DEPTH(DEPTH)) u_out_buf (
      .clk_i   (clock),
      .rst_i   (reset),
      .push_i  (buf_push),
      .din_i   (buf_din),
      .pop_i   (buf_pop),
      .flush_i (redirect_valid),
      .dout_o  (buf_dout),
      .count_o (buf_cnt),
      .full_o  (buf_full),
      .empty_o (buf_empty)
   );

   // Next PC and stale-response count; redirect turns every live fetch stale
   always_comb begin
      pc_d   = pc_q;
      drop_d = drop_q;
      if (redirect_valid) begin
         pc_d   = align4(redirect_pc);
         drop_d = drop_q + DW'(live_cnt) + DW'(req_hs) - DW'(rsp_stale || rsp_live);
      end else begin
         if (req_hs)    pc_d   = pc_q + XLEN'(4);
         if (rsp_stale) drop_d = drop_q - DW'(1);
      end
   end

   // PC and drop counter registers
   always_ff @(posedge clock) begin
      if (reset) begin
         pc_q   <= RESET_PC;
         drop_q <= '0;
      end else begin
         pc_q   <= pc_d;
         drop_q <= drop_d;
      end
   end

   a_live_ovf: assert property (@(posedge clock) disable iff (reset)
                                !(live_push && live_full && !live_pop));
   a_buf_ovf:  assert property (@(posedge clock) disable iff (reset)
                                !(buf_push && buf_full && !buf_pop));

`ifdef IFU_PERF_EN
   logic [63:0] fetch_cnt_q, stall_cnt_q;

   // Saturating delivery and request-stall counters
   always_ff @(posedge clock) begin
      if (reset) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (buf_pop && (fetch_cnt_q != '1)) fetch_cnt_q <= fetch_cnt_q + 64'd1;
         if (bus.imem_req_valid && !bus.imem_req_ready && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + 64'd1;
      end
   end

   assign perf_fetch_cnt = fetch_cnt_q;
   assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ifu_fetch_stage.sv
// Scoreboard bench for ifu_fetch_stage with an in-order fixed-latency memory model.
`timescale 1ns/1ps
module tb_ifu_fetch_stage;
   import rvnoob_pkg::*;

   localparam int unsigned DEPTH  = 2;
   localparam logic [63:0] RST_PC = 64'h8000_0000;

   typedef struct { logic [63:0] pc; logic [31:0] inst; } exp_t;
   typedef struct { int due; logic [31:0] data; } mem_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        halt;

   ifu_fetch_stage_if bus();

`ifdef IFU_PERF_EN
   logic [63:0] perf_fetch_cnt, perf_stall_cnt;
`endif

   ifu_fetch_stage #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
      .clock          (clock),
      .reset          (reset),
      .bus            (bus),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt)
`ifdef IFU_PERF_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   always #5 clock = ~clock;

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          mem_lat = 1;
   logic        req_ready_v = 1'b0, out_ready_v = 1'b0, halt_v = 1'b0;
   logic        redir_v = 1'b0, reset_v = 1'b1;
   logic [63:0] redir_pc_v = '0;
   logic [63:0] exp_pc = RST_PC;
   logic [63:0] ebreak_addr = '1;
   exp_t        exp_q[$];
   mem_t        mem_q[$];
   logic [63:0] req_log[$];
   logic [63:0] out_log[$];
   int          delivered = 0, ebreak_cnt = 0, late_rsp = 0;
   bit          saw_req = 0, saw_rsp = 0, saw_ebreak_rsp = 0;

   function automatic logic [31:0] word_of(input logic [63:0] a);
      if (a == ebreak_addr) return EBREAK;
      return {a[19:0], 12'h013};
   endfunction

   function automatic logic [63:0] first_of(input logic [63:0] q[$]);
      if (q.size() == 0) return '1;
      return q[0];
   endfunction

   // One clock: drive inputs at negedge, sample #1 later, score handshakes
   task automatic cycle();
      exp_t e;
      mem_t m;
      @(negedge clock);
      reset              = reset_v;
      bus.imem_req_ready = req_ready_v;
      bus.out_ready      = out_ready_v;
      halt               = halt_v;
      redirect_valid     = redir_v;
      redirect_pc        = redir_pc_v;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         m = mem_q.pop_front();
         bus.imem_rsp_valid = 1'b1;
         bus.imem_rsp_data  = m.data;
      end
      #1;
      saw_req = 0;
      saw_rsp = bus.imem_rsp_valid;
      if (bus.imem_rsp_valid && bus.imem_rsp_data == EBREAK) saw_ebreak_rsp = 1;
      if (reset_v) begin
         total++;
         if (bus.imem_req_valid !== 1'b0) begin
            bad++; $display("FAIL reset_req_valid: got %b want 0", bus.imem_req_valid);
         end
         total++;
         if (bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
         end
         exp_q.delete();
         exp_pc = RST_PC;
      end else begin
         if (bus.imem_rsp_valid) late_rsp++;
         if (bus.out_valid === 1'b1 && bus.out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL out_unexpected: got pc=%h inst=%h want no output", bus.out_pc, bus.out_inst);
            end else begin
               e = exp_q.pop_front();
               if (bus.out_pc !== e.pc || bus.out_inst !== e.inst) begin
                  bad++;
                  $display("FAIL out_data: got pc=%h inst=%h want pc=%h inst=%h",
                           bus.out_pc, bus.out_inst, e.pc, e.inst);
               end
            end
            out_log.push_back(bus.out_pc);
            delivered++;
            if (bus.out_inst == EBREAK) ebreak_cnt++;
         end
         if (bus.imem_req_valid === 1'b1 && req_ready_v) begin
            saw_req = 1;
            total++;
            if (bus.imem_req_addr !== exp_pc) begin
               bad++; $display("FAIL req_addr: got %h want %h", bus.imem_req_addr, exp_pc);
            end
            req_log.push_back(bus.imem_req_addr);
            m.due  = cyc + mem_lat;
            m.data = word_of(bus.imem_req_addr);
            mem_q.push_back(m);
            if (!redir_v) begin
               e.pc   = exp_pc;
               e.inst = word_of(exp_pc);
               exp_q.push_back(e);
            end
            exp_pc = exp_pc + 64'd4;
         end
         if (redir_v) begin
            exp_q.delete();
            exp_pc = {redir_pc_v[63:2], 2'b00};
         end
      end
      cyc++;
   endtask

   // Stop fetching and let all outstanding work reach decode
   task automatic drain();
      int n = 0;
      req_ready_v = 0; out_ready_v = 1; redir_v = 0; halt_v = 0;
      while ((mem_q.size() > 0 || exp_q.size() > 0) && n < 60) begin
         cycle(); n++;
      end
      cycle(); cycle();
      total++;
      if (mem_q.size() != 0 || exp_q.size() != 0) begin
         bad++; $display("FAIL drain_timeout: got mem=%0d exp=%0d pending want 0", mem_q.size(), exp_q.size());
      end
   endtask

   task automatic test_reset();
      reset_v = 1; cycle(); cycle();
      reset_v = 0; req_ready_v = 0; out_ready_v = 1; cycle();
      #1;
      total++;
      if (bus.imem_req_valid !== 1'b1) begin
         bad++; $display("FAIL post_reset_req_valid: got %b want 1", bus.imem_req_valid);
      end
      total++;
      if (bus.imem_req_addr !== RST_PC) begin
         bad++; $display("FAIL post_reset_addr: got %h want %h", bus.imem_req_addr, RST_PC);
      end
      total++;
      if (bus.out_valid !== 1'b0) begin
         bad++; $display("FAIL post_reset_out_valid: got %b want 0", bus.out_valid);
      end
   endtask

   task automatic test_stream();
      logic [63:0] a[3];
      mem_lat = 1; req_ready_v = 1; out_ready_v = 1;
      req_log.delete(); out_log.delete();
      repeat (12) cycle();
      for (int i = 0; i < 3; i++) a[i] = (req_log.size() > i) ? req_log[i] : '1;
      for (int i = 0; i < 3; i++) begin
         total++;
         if (a[i] !== RST_PC + 64'(4 * i)) begin
            bad++; $display("FAIL stream_addr%0d: got %h want %h", i, a[i], RST_PC + 64'(4 * i));
         end
      end
      total++;
      if (first_of(out_log) !== RST_PC) begin
         bad++; $display("FAIL stream_first_out: got %h want %h", first_of(out_log), RST_PC);
      end
      total++;
      if (out_log.size() < 4) begin
         bad++; $display("FAIL stream_count: got %0d want >=4", out_log.size());
      end
   endtask

   task automatic test_backpressure();
      int d0;
      out_ready_v = 0; req_ready_v = 1;
      repeat (10) cycle();
      #1;
      total++;
      if (exp_q.size() != DEPTH) begin
         bad++; $display("FAIL bp_buffered: got %0d want %0d", exp_q.size(), DEPTH);
      end
      total++;
      if (bus.imem_req_valid !== 1'b0) begin
         bad++; $display("FAIL bp_req_valid: got %b want 0", bus.imem_req_valid);
      end
      total++;
      if (bus.out_valid !== 1'b1) begin
         bad++; $display("FAIL bp_out_valid: got %b want 1", bus.out_valid);
      end
      d0 = delivered;
      drain();
      total++;
      if (delivered - d0 != DEPTH) begin
         bad++; $display("FAIL bp_drain_count: got %0d want %0d", delivered - d0, DEPTH);
      end
   endtask

   task automatic test_redirect_inflight();
      int n0;
      mem_lat = 3; req_ready_v = 1; out_ready_v = 1;
      n0 = req_log.size();
      cycle(); cycle();
      total++;
      if (req_log.size() - n0 != 2) begin
         bad++; $display("FAIL redir_inflight_setup: got %0d reqs want 2", req_log.size() - n0);
      end
      req_ready_v = 0; redir_v = 1; redir_pc_v = 64'h8000_0103;
      cycle();
      redir_v = 0; req_ready_v = 1;
      req_log.delete(); out_log.delete();
      repeat (12) cycle();
      total++;
      if (first_of(req_log) !== 64'h8000_0100) begin
         bad++; $display("FAIL redir_next_addr: got %h want 8000000000000100", first_of(req_log));
      end
      total++;
      if (first_of(out_log) !== 64'h8000_0100) begin
         bad++; $display("FAIL redir_first_out: got %h want 8000000000000100", first_of(out_log));
      end
      drain();
   endtask

   task automatic test_redirect_same_cycle();
      mem_lat = 1; req_ready_v = 1; out_ready_v = 1;
      cycle();
      redir_v = 1; redir_pc_v = 64'h8000_0200;
      cycle();
      total++;
      if (!(saw_req && saw_rsp)) begin
         bad++; $display("FAIL redir_same_setup: got req=%0d rsp=%0d want 1 1", saw_req, saw_rsp);
      end
      redir_v = 0;
      out_log.delete();
      repeat (8) cycle();
      total++;
      if (first_of(out_log) !== 64'h8000_0200) begin
         bad++; $display("FAIL redir_same_first_out: got %h want 8000000000000200", first_of(out_log));
      end
      drain();
   endtask

   task automatic test_halt_ebreak();
      int n = 0;
      mem_lat = 2; out_ready_v = 1; req_ready_v = 0;
      ebreak_addr = 64'h8000_0300; ebreak_cnt = 0; saw_ebreak_rsp = 0;
      redir_v = 1; redir_pc_v = 64'h8000_0300;
      cycle();
      redir_v = 0; req_ready_v = 1;
      while (!saw_ebreak_rsp && n < 20) begin
         cycle(); n++;
      end
      total++;
      if (!saw_ebreak_rsp) begin
         bad++; $display("FAIL halt_ebreak_rsp: got none want ebreak response");
      end
      halt_v = 1;
      req_log.delete();
      repeat (15) cycle();
      total++;
      if (req_log.size() != 0) begin
         bad++; $display("FAIL halt_reqs: got %0d want 0", req_log.size());
      end
      total++;
      if (ebreak_cnt != 1) begin
         bad++; $display("FAIL halt_ebreak_seen: got %0d want 1", ebreak_cnt);
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++; $display("FAIL halt_outstanding: got %0d undelivered want 0", exp_q.size());
      end
      halt_v = 0;
      repeat (6) cycle();
      total++;
      if (first_of(req_log) !== 64'h8000_0308) begin
         bad++; $display("FAIL halt_resume_addr: got %h want 8000000000000308", first_of(req_log));
      end
      ebreak_addr = '1;
      drain();
   endtask

   task automatic test_reset_midop();
      int n0, d0, n = 0;
      mem_lat = 3; req_ready_v = 1; out_ready_v = 1;
      n0 = req_log.size();
      cycle(); cycle();
      total++;
      if (req_log.size() - n0 != 2) begin
         bad++; $display("FAIL rst_mid_setup: got %0d reqs want 2", req_log.size() - n0);
      end
      reset_v = 1; req_ready_v = 0;
      cycle();
      reset_v = 0; late_rsp = 0; d0 = delivered;
      while (mem_q.size() > 0 && n < 20) begin
         cycle(); n++;
      end
      cycle();
      total++;
      if (late_rsp != 2) begin
         bad++; $display("FAIL rst_mid_late_rsp: got %0d want 2", late_rsp);
      end
      #1;
      total++;
      if (bus.out_valid !== 1'b0 || delivered != d0) begin
         bad++; $display("FAIL rst_mid_ignored: got out_valid=%b delivered=%0d want 0 %0d",
                         bus.out_valid, delivered - d0, 0);
      end
      req_ready_v = 1;
      req_log.delete(); out_log.delete();
      repeat (8) cycle();
      total++;
      if (first_of(req_log) !== RST_PC) begin
         bad++; $display("FAIL rst_mid_first_req: got %h want %h", first_of(req_log), RST_PC);
      end
      total++;
      if (first_of(out_log) !== RST_PC) begin
         bad++; $display("FAIL rst_mid_first_out: got %h want %h", first_of(out_log), RST_PC);
      end
      drain();
   endtask

   initial begin
      reset              = 1'b1;
      halt               = 1'b0;
      redirect_valid     = 1'b0;
      redirect_pc        = '0;
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      bus.out_ready      = 1'b0;
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_inflight();
      test_redirect_same_cycle();
      test_halt_ebreak();
      test_reset_midop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
